// File: rtl/addsub_bist_pkg.sv
// Shared definitions for the addsub_4bit self-test controller.
//   bist_state_e : FSM state encodings (also exported on the debug port)
//   MODE_*       : sub-select policy codes sampled at start
//   LFSR_TAPS    : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   ERR_MAX      : saturation value of the mismatch counter
//   lfsr_next()  : one left shift of the Fibonacci LFSR, feedback into bit 0
package addsub_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } bist_state_e;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ALT  = 2'b10;
  localparam logic [1:0] MODE_RAND = 2'b11;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [7:0]  ERR_MAX   = 8'd255;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/addsub_lfsr16.sv
// 16-bit Fibonacci LFSR used as the operand source of the self-test.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads SEED)
//   load_i     : reload SEED (has priority over step_i)
//   step_i     : advance one position
//   state_o    : current 16-bit register value
module addsub_lfsr16
  import addsub_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= SEED;
    end else if (step_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/addsub_bist_ctrl.sv
// Stimulus-and-check engine for the addsub_4bit adder/subtractor.
// Each vector: APPLY registers operands from the LFSR, SETTLE waits
// SETTLE_CYCLES, CHECK compares the DUT result against the golden model.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : pulse, starts a run from IDLE or DONE
//   mode                  : sub policy (00 add, 01 sub, 10 alternate, 11 lfsr[15])
//   op_a, op_b, sub       : stimulus to the adder/subtractor
//   dut_sum, dut_ovfl     : response from the adder/subtractor
//   busy, done, pass      : run status (pass valid while done)
//   err_count, vec_count  : mismatching vectors (saturating), vectors checked
//   fail_a/b/sub/sum/ovfl : first-fail capture
//   dbg_state             : current FSM state
// Optional feature: ADDSUB_BIST_FAIL_CAPTURE_EN builds the first-fail capture
// registers; when undefined the fail_* ports are tied to 0.
// Handshake: none; the DUT is assumed combinational and settled after
// SETTLE_CYCLES, and start is only honoured in IDLE or DONE.
module addsub_bist_ctrl
  import addsub_bist_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned NUM_VECTORS   = 100,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             sub,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_ovfl,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [15:0]      vec_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_sub,
  output logic [WIDTH-1:0] fail_sum,
  output logic             fail_ovfl,
  output logic [2:0]       dbg_state
);

  localparam logic [15:0] NV      = 16'(NUM_VECTORS);
  localparam logic [15:0] SC_LAST = 16'(SETTLE_CYCLES - 1);

  bist_state_e      state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             sub_q, sub_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      vec_q, vec_d;
  logic [15:0]      settle_q, settle_d;
  logic             lfsr_load, lfsr_step, start_run, check_en;
  logic [15:0]      lfsr;

  logic [WIDTH-1:0] exp_sum, b_eff;
  logic             exp_ovfl, mismatch;

  addsub_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .state_o (lfsr)
  );

  // Golden model. For subtraction B enters the adder inverted, so overflow
  // is "A and effective B share a sign that the result does not".
  always_comb begin
    exp_sum  = sub_q ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
    b_eff    = sub_q ? ~op_b_q : op_b_q;
    exp_ovfl = (op_a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
               (exp_sum[WIDTH-1] != op_a_q[WIDTH-1]);
    // Case inequality so X/Z from the DUT is a mismatch.
    mismatch = (dut_sum !== exp_sum) || (dut_ovfl !== exp_ovfl);
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sub_d     = sub_q;
    err_d     = err_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    start_run = 1'b0;
    check_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_run = 1'b1;
          lfsr_load = 1'b1;
          mode_d    = mode;
          err_d     = '0;
          vec_d     = '0;
          state_d   = (NV == 16'd0) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        op_a_d   = lfsr[WIDTH-1:0];
        op_b_d   = lfsr[2*WIDTH-1:WIDTH];
        case (mode_q)
          MODE_ADD: sub_d = 1'b0;
          MODE_SUB: sub_d = 1'b1;
          MODE_ALT: sub_d = vec_q[0];
          default:  sub_d = lfsr[15];
        endcase
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SC_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      ST_CHECK: begin
        check_en  = 1'b1;
        lfsr_step = 1'b1;
        vec_d     = vec_q + 16'd1;
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + 8'd1;
        end
        state_d = (vec_d == NV) ? ST_DONE : ST_APPLY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      sub_q    <= 1'b0;
      err_q    <= '0;
      vec_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      sub_q    <= sub_d;
      err_q    <= err_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
    end
  end

`ifdef ADDSUB_BIST_FAIL_CAPTURE_EN
  logic             fail_valid_q;
  logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_sum_q;
  logic             fail_sub_q, fail_ovfl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_sub_q   <= 1'b0;
      fail_sum_q   <= '0;
      fail_ovfl_q  <= 1'b0;
    end else if (start_run) begin
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_sub_q   <= 1'b0;
      fail_sum_q   <= '0;
      fail_ovfl_q  <= 1'b0;
    end else if (check_en && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_a_q     <= op_a_q;
      fail_b_q     <= op_b_q;
      fail_sub_q   <= sub_q;
      fail_sum_q   <= dut_sum;
      fail_ovfl_q  <= dut_ovfl;
    end
  end

  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_sub  = fail_sub_q;
  assign fail_sum  = fail_sum_q;
  assign fail_ovfl = fail_ovfl_q;
`else
  assign fail_a    = '0;
  assign fail_b    = '0;
  assign fail_sub  = 1'b0;
  assign fail_sum  = '0;
  assign fail_ovfl = 1'b0;
`endif

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign sub       = sub_q;
  assign busy      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                     (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == 8'd0);
  assign err_count = err_q;
  assign vec_count = vec_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addsub_bist_ctrl.sv
// Bench for addsub_bist_ctrl. Five controller instances with different
// run lengths / seeds, each beside a behavioural adder/subtractor that can
// carry a fault (1: sum[0] stuck 0, 2: outputs inverted, 3: ovfl stuck 0).
module tb_addsub_bist_ctrl;
  import addsub_bist_pkg::*;

  localparam int NI = 5;
  // Instance g uses bits [g*16 +: 16].
  localparam logic [NI*16-1:0] NV_P   = {16'd4, 16'd4, 16'd300, 16'd0, 16'd100};
  localparam logic [NI*16-1:0] SEED_P = {16'h000C, 16'h0017, 16'hACE1, 16'hACE1, 16'hACE1};

`ifdef ADDSUB_BIST_FAIL_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT instances ----------------
  logic [NI-1:0] start_r = '0;
  logic [1:0]    mode_r  [NI];
  logic [1:0]    fault_r [NI];

  logic [3:0]  op_a_w [NI], op_b_w [NI], fail_a_w [NI], fail_b_w [NI], fail_sum_w [NI];
  logic        sub_w [NI], busy_w [NI], done_w [NI], pass_w [NI];
  logic        fail_sub_w [NI], fail_ovfl_w [NI];
  logic [7:0]  err_w [NI];
  logic [15:0] vec_w [NI];
  logic [2:0]  dbg_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [3:0] m_sum;
    logic       m_ovfl;
    int         ia, ib, ir;

    addsub_bist_ctrl #(
      .WIDTH         (4),
      .NUM_VECTORS   (int'(NV_P[g*16 +: 16])),
      .SETTLE_CYCLES (1),
      .LFSR_SEED     (SEED_P[g*16 +: 16])
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_r[g]),
      .mode      (mode_r[g]),
      .op_a      (op_a_w[g]),
      .op_b      (op_b_w[g]),
      .sub       (sub_w[g]),
      .dut_sum   (m_sum),
      .dut_ovfl  (m_ovfl),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .pass      (pass_w[g]),
      .err_count (err_w[g]),
      .vec_count (vec_w[g]),
      .fail_a    (fail_a_w[g]),
      .fail_b    (fail_b_w[g]),
      .fail_sub  (fail_sub_w[g]),
      .fail_sum  (fail_sum_w[g]),
      .fail_ovfl (fail_ovfl_w[g]),
      .dbg_state (dbg_w[g])
    );

    // Behavioural adder/subtractor: signed integer arithmetic, range check
    // for overflow.
    always_comb begin
      ia     = int'($signed(op_a_w[g]));
      ib     = int'($signed(op_b_w[g]));
      ir     = sub_w[g] ? (ia - ib) : (ia + ib);
      m_sum  = ir[3:0];
      m_ovfl = (ir > 7) || (ir < -8);
      case (fault_r[g])
        2'd1: m_sum[0] = 1'b0;
        2'd2: begin
          m_sum  = ~ir[3:0];
          m_ovfl = !((ir > 7) || (ir < -8));
        end
        2'd3: m_ovfl = 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]  inst;
    logic        pass;
    logic [7:0]  err;
    logic [15:0] vec;
    logic [31:0] lat;
    logic [31:0] start_cyc;
    logic [3:0]  fa;
    logic [3:0]  fb;
    logic        fsub;
    logic [3:0]  fsum;
    logic        fovfl;
  } res_t;

  typedef struct packed {
    logic [3:0] inst;
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
  } vec_t;

  res_t res_q[$];
  vec_t vec_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic res_t mk_res(input int inst, input bit p, input int e, input int v,
                                  input int lat, input logic [3:0] fa, input logic [3:0] fb,
                                  input logic fs, input logic [3:0] fsum, input logic fo);
    res_t r;
    r.inst      = 4'(inst);
    r.pass      = p;
    r.err       = 8'(e);
    r.vec       = 16'(v);
    r.lat       = 32'(lat);
    r.start_cyc = '0;
    r.fa        = CAP ? fa : 4'h0;
    r.fb        = CAP ? fb : 4'h0;
    r.fsub      = CAP ? fs : 1'b0;
    r.fsum      = CAP ? fsum : 4'h0;
    r.fovfl     = CAP ? fo : 1'b0;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic [NI-1:0] done_prev  = '0;
  logic          busy1_seen = 1'b0;

  always @(negedge clk) begin
    if (busy_w[1]) busy1_seen <= 1'b1;
    for (int g = 0; g < NI; g++) begin
      if (vec_q.size() > 0 && vec_q[0].inst == 4'(g) && dbg_w[g] == ST_CHECK) begin
        vec_t v;
        v = vec_q.pop_front();
        chk($sformatf("vec_op_a[%0d]", g), 32'(op_a_w[g]), 32'(v.a));
        chk($sformatf("vec_op_b[%0d]", g), 32'(op_b_w[g]), 32'(v.b));
        chk($sformatf("vec_sub[%0d]", g), 32'(sub_w[g]), 32'(v.sub));
      end
      if (done_w[g] && !done_prev[g]) begin
        if (res_q.size() == 0 || res_q[0].inst != 4'(g)) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: inst %0d raised done with no run expected", g);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk($sformatf("pass[%0d]", g), 32'(pass_w[g]), 32'(r.pass));
          chk($sformatf("err_count[%0d]", g), 32'(err_w[g]), 32'(r.err));
          chk($sformatf("vec_count[%0d]", g), 32'(vec_w[g]), 32'(r.vec));
          chk($sformatf("done_latency[%0d]", g), 32'(cyc) - r.start_cyc, r.lat);
          chk($sformatf("busy_at_done[%0d]", g), 32'(busy_w[g]), 32'd0);
          chk($sformatf("fail_a[%0d]", g), 32'(fail_a_w[g]), 32'(r.fa));
          chk($sformatf("fail_b[%0d]", g), 32'(fail_b_w[g]), 32'(r.fb));
          chk($sformatf("fail_sub[%0d]", g), 32'(fail_sub_w[g]), 32'(r.fsub));
          chk($sformatf("fail_sum[%0d]", g), 32'(fail_sum_w[g]), 32'(r.fsum));
          chk($sformatf("fail_ovfl[%0d]", g), 32'(fail_ovfl_w[g]), 32'(r.fovfl));
        end
      end
      done_prev[g] <= done_w[g];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_vec(input int g, input logic [3:0] a, input logic [3:0] b, input logic s);
    vec_t v;
    v.inst = 4'(g);
    v.a    = a;
    v.b    = b;
    v.sub  = s;
    vec_q.push_back(v);
  endtask

  task automatic issue(input int g, input res_t r);
    @(negedge clk);
    r.start_cyc = 32'(cyc);
    res_q.push_back(r);
    start_r[g] = 1'b1;
    @(negedge clk);
    start_r[g] = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while ((res_q.size() != 0 || vec_q.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 32'(res_q.size() + vec_q.size()), 32'd0);
    res_q.delete();
    vec_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_vec(input int g, input int target, input int max_cycles);
    int n;
    n = 0;
    while (vec_w[g] != 16'(target) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("reach_vec_%0d", target), 32'(vec_w[g]), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] s;
    logic [3:0]  a, b, sm;
    int          odd_cnt;

    for (int g = 0; g < NI; g++) begin
      mode_r[g]  = 2'b00;
      fault_r[g] = 2'd0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_done", 32'(done_w[0]), 32'd0);
    chk("rst_pass", 32'(pass_w[0]), 32'd0);
    chk("rst_err", 32'(err_w[0]), 32'd0);
    chk("rst_vec", 32'(vec_w[0]), 32'd0);
    chk("rst_op_a", 32'(op_a_w[0]), 32'd0);
    chk("rst_state", 32'(dbg_w[0]), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: correct DUT, subtract, 100 vectors
    mode_r[0]  = 2'b01;
    fault_r[0] = 2'd0;
    push_vec(0, 4'h1, 4'hE, 1'b1);
    push_vec(0, 4'h3, 4'hC, 1'b1);
    push_vec(0, 4'h7, 4'h8, 1'b1);
    issue(0, mk_res(0, 1'b1, 0, 100, 301, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0));
    wait_drain("t1", 1000);

    // 2: sum[0] stuck at 0, add, restart from DONE
    s       = 16'hACE1;
    odd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      a  = s[3:0];
      b  = s[7:4];
      sm = a + b;
      if (sm[0]) odd_cnt++;
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    mode_r[0]  = 2'b00;
    fault_r[0] = 2'd1;
    push_vec(0, 4'h1, 4'hE, 1'b0);
    // first vector 1+E=F is odd: DUT reports E, no overflow
    issue(0, mk_res(0, 1'b0, odd_cnt, 100, 301, 4'h1, 4'hE, 1'b0, 4'hE, 1'b0));
    wait_drain("t2", 1000);

    // 3: zero-length run
    issue(1, mk_res(1, 1'b1, 0, 0, 1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0));
    wait_drain("t3", 20);

    // 5: inverted outputs, 300 vectors, error counter saturates
    fault_r[2] = 2'd2;
    issue(2, mk_res(2, 1'b0, 255, 300, 901, 4'h1, 4'hE, 1'b0, 4'h0, 1'b1));
    wait_drain("t5", 2000);

    // 6: alternate mode, ovfl stuck at 0; 7+1 and 8-1 overflow vectors
    mode_r[3]  = 2'b10;
    fault_r[3] = 2'd3;
    push_vec(3, 4'h7, 4'h1, 1'b0);
    push_vec(3, 4'hE, 4'h2, 1'b1);
    push_vec(3, 4'hC, 4'h5, 1'b0);
    push_vec(3, 4'h8, 4'hB, 1'b1);
    issue(3, mk_res(3, 1'b0, 1, 4, 13, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0));
    wait_drain("t6a", 100);

    mode_r[4]  = 2'b10;
    fault_r[4] = 2'd3;
    push_vec(4, 4'hC, 4'h0, 1'b0);
    push_vec(4, 4'h8, 4'h1, 1'b1);
    push_vec(4, 4'h0, 4'h3, 1'b0);
    push_vec(4, 4'h0, 4'h6, 1'b1);
    issue(4, mk_res(4, 1'b0, 1, 4, 13, 4'h8, 4'h1, 1'b1, 4'h7, 1'b0));
    wait_drain("t6b", 100);

    // 4: start while busy is ignored; reset mid-run aborts
    mode_r[0]  = 2'b01;
    fault_r[0] = 2'd0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_vec(0, 10, 200);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    chk("busy_after_restart_pulse", 32'(busy_w[0]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("vec_after_restart_pulse", 32'(vec_w[0]), 32'd11);
    wait_vec(0, 50, 400);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_done", 32'(done_w[0]), 32'd0);
    chk("abort_pass", 32'(pass_w[0]), 32'd0);
    chk("abort_err", 32'(err_w[0]), 32'd0);
    chk("abort_vec", 32'(vec_w[0]), 32'd0);
    chk("abort_op_a", 32'(op_a_w[0]), 32'd0);
    chk("abort_op_b", 32'(op_b_w[0]), 32'd0);
    chk("abort_sub", 32'(sub_w[0]), 32'd0);
    chk("abort_state", 32'(dbg_w[0]), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_abort_state", 32'(dbg_w[0]), 32'(ST_IDLE));
    chk("idle_after_abort_done", 32'(done_w[0]), 32'd0);

    // Final report
    chk("zero_len_never_busy", 32'(busy1_seen), 32'd0);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
